// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode map, FSM state encoding
// and instruction word field layout.
package alu_pkg;

  localparam logic [6:0] OP_ADD  = 7'd0;
  localparam logic [6:0] OP_SUB  = 7'd1;
  localparam logic [6:0] OP_SHL  = 7'd2;
  localparam logic [6:0] OP_SHR  = 7'd3;
  localparam logic [6:0] OP_MOV  = 7'd4;
  localparam logic [6:0] OP_LDL  = 7'd5;
  localparam logic [6:0] OP_LDH  = 7'd6;
  localparam logic [6:0] OP_MOV2 = 7'd7;
  localparam logic [6:0] OP_EQ   = 7'd8;
  localparam logic [6:0] OP_NE   = 7'd9;
  localparam logic [6:0] OP_GT   = 7'd10;
  localparam logic [6:0] OP_LT   = 7'd11;
  localparam logic [6:0] OP_NF1  = 7'd12;
  localparam logic [6:0] OP_NF2  = 7'd13;
  localparam logic [6:0] OP_BR   = 7'd14;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int RA_LSB  = 11;
  localparam int HL_BIT  = 15;
  localparam int RB_LSB  = 16;
  localparam int IMM_LSB = 16;
  localparam int REG_W   = 4;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_e;

  function automatic logic [6:0] f_opc(input logic [31:0] w);
    return w[OPC_LSB +: 7];
  endfunction

  function automatic logic [REG_W-1:0] f_rd(input logic [31:0] w);
    return w[RD_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] f_ra(input logic [31:0] w);
    return w[RA_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] f_rb(input logic [31:0] w);
    return w[RB_LSB +: REG_W];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] w);
    return w[IMM_LSB +: 16];
  endfunction

  function automatic logic is_reg_write(input logic [6:0] op);
    return (op <= OP_MOV2);
  endfunction

  function automatic logic is_flag_op(input logic [6:0] op);
    return (op >= OP_EQ) && (op <= OP_NF2);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of the instruction-memory fetch port and the ALU drive/response
// signals; master is the sequencer, slave is the memory/ALU side.
interface alu_sequencer_if;
  import alu_pkg::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_reg8;
  logic [15:0] alu_value;
  logic        alu_highlow;
  logic [6:0]  alu_instr;
  logic        alu_f1;
  logic        alu_f2;
  logic [31:0] alu_c;
  logic        alu_flag;
  logic        alu_addrch;
  logic [31:0] alu_naddr;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    output alu_a, alu_b, alu_reg8, alu_value, alu_highlow, alu_instr, alu_f1, alu_f2,
    input  alu_c, alu_flag, alu_addrch, alu_naddr
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    input  alu_a, alu_b, alu_reg8, alu_value, alu_highlow, alu_instr, alu_f1, alu_f2,
    output alu_c, alu_flag, alu_addrch, alu_naddr
  );
endinterface

// File: rtl/alu_sequencer_regfile.sv
// 16x32 register file: two asynchronous read ports, a fixed R8 tap and one
// synchronous write port, cleared by synchronous reset.
module regfile16x32
  import alu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [REG_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [REG_W-1:0] raddr_a,
  input  logic [REG_W-1:0] raddr_b,
  output logic [31:0]      rdata_a,
  output logic [31:0]      rdata_b,
  output logic [31:0]      rdata_8
);

  logic [31:0] mem_q [NREGS];
  logic [31:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];
  assign rdata_8 = mem_q[8];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback sequencer that drives the ALU and retires
// its results into the register file, the F1/F2 flags and the PC.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [6:0]  HALT_OP  = 7'd127,
  parameter int          NREGS    = 16
) (
  input  logic               clock,
  input  logic               reset,
  alu_sequencer_if.master    bus,
  output logic               halted,
  output logic [31:0]        pc
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        req_q, req_d;
  logic [31:0] a_q, a_d, b_q, b_d, r8_q, r8_d;
  logic [31:0] c_q, c_d, naddr_q, naddr_d;
  logic        flag_q, flag_d, addrch_q, addrch_d;
  logic        f1_q, f1_d, f2_q, f2_d;

  logic        rf_we;
  logic [31:0] rd_a, rd_b, rd_8;
  logic [6:0]  opc;

  assign opc = f_opc(ir_q);

  regfile16x32 #(.NREGS(NREGS)) u_rf (
    .clock   (clock),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (f_rd(ir_q)),
    .wdata   (c_q),
    .raddr_a (f_ra(ir_q)),
    .raddr_b (f_rb(ir_q)),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .rdata_8 (rd_8)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    r8_d     = r8_q;
    c_d      = c_q;
    naddr_d  = naddr_q;
    flag_d   = flag_q;
    addrch_d = addrch_q;
    f1_d     = f1_q;
    f2_d     = f2_q;
    rf_we    = 1'b0;

    unique case (state_q)
      // An ack only counts while our request is actually on the bus.
      ST_FETCH: begin
        if (req_q && bus.imem_ack) begin
          ir_d    = bus.imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d     = rd_a;
        b_d     = rd_b;
        r8_d    = rd_8;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        c_d      = bus.alu_c;
        flag_d   = bus.alu_flag;
        addrch_d = bus.alu_addrch;
        naddr_d  = bus.alu_naddr;
        state_d  = (opc == HALT_OP) ? ST_HALT : ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        pc_d  = pc_q + 32'd4;
        rf_we = is_reg_write(opc);
        if (is_flag_op(opc)) begin
          f2_d = f1_q;
          f1_d = flag_q;
        end
        if ((opc == OP_BR) && addrch_q) pc_d = naddr_q;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    req_d = (state_d == ST_FETCH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      req_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      r8_q     <= '0;
      c_q      <= '0;
      naddr_q  <= '0;
      flag_q   <= 1'b0;
      addrch_q <= 1'b0;
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      req_q    <= req_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r8_q     <= r8_d;
      c_q      <= c_d;
      naddr_q  <= naddr_d;
      flag_q   <= flag_d;
      addrch_q <= addrch_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_reg8    = r8_q;
  assign bus.alu_value   = f_imm(ir_q);
  assign bus.alu_highlow = ir_q[HL_BIT];
  assign bus.alu_instr   = (state_q == ST_EXECUTE) ? opc : 7'd0;
  assign bus.alu_f1      = f1_q;
  assign bus.alu_f2      = f2_q;
  assign halted          = (state_q == ST_HALT);
  assign pc              = pc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: acts as instruction memory and ALU, and checks
// the sequencer against an instruction-level model of the register file, flags and PC.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        halted, halted2;
  logic [31:0] pc, pc2;

  alu_sequencer_if bus();
  alu_sequencer_if bus2();

  alu_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .bus(bus), .halted(halted), .pc(pc));

  alu_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .reset(reset), .bus(bus2), .halted(halted2), .pc(pc2));

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_reg [16];
  logic        m_f1, m_f2;
  logic [31:0] m_pc;

  typedef struct {
    logic [31:0] word;
    int          wt;
    logic [31:0] c;
    logic        flg;
    logic        br;
    logic [31:0] na;
    logic [31:0] exp_pc;
    logic        exp_f1;
    logic        exp_f2;
  } vec_t;

  vec_t vt [10];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [3:0] rd,
                                      input logic [3:0] ra, input logic hl,
                                      input logic [15:0] imm);
    return {imm, hl, ra, rd, op};
  endfunction

  task automatic model_reset(input logic [31:0] rpc);
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_f1 = 1'b0;
    m_f2 = 1'b0;
    m_pc = rpc;
  endtask

  task automatic rand_alu();
    bus.alu_c      = $urandom;
    bus.alu_flag   = 1'($urandom);
    bus.alu_addrch = 1'($urandom);
    bus.alu_naddr  = $urandom;
  endtask

  // One full instruction: fetch with wt wait cycles, then decode/execute/retire.
  task automatic run_instr(input logic [31:0] word, input int wt, input logic [31:0] c,
                           input logic flg, input logic br, input logic [31:0] na);
    int         n;
    bit         stable;
    logic [6:0] op;
    logic [3:0] rd, ra, rb;
    op = word[6:0];
    rd = word[10:7];
    ra = word[14:11];
    rb = word[19:16];
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk("fetch_req", bus.imem_req, 1);
    chk("fetch_addr", bus.imem_addr, m_pc);
    chk("halted_low", halted, 0);
    stable = 1'b1;
    for (int i = 0; i < wt; i++) begin
      rand_alu();
      step();
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || bus.alu_instr !== 7'd0) stable = 1'b0;
    end
    chk("fetch_hold", stable, 1);
    bus.imem_ack  = 1'b1;
    bus.imem_data = word;
    step();
    bus.imem_ack  = 1'b0;
    bus.imem_data = $urandom;
    chk("decode_req", bus.imem_req, 0);
    chk("decode_instr", bus.alu_instr, 0);
    step();
    chk("exec_instr", bus.alu_instr, op);
    chk("exec_a", bus.alu_a, m_reg[ra]);
    chk("exec_b", bus.alu_b, m_reg[rb]);
    chk("exec_r8", bus.alu_reg8, m_reg[8]);
    chk("exec_value", bus.alu_value, word[31:16]);
    chk("exec_hl", bus.alu_highlow, word[15]);
    chk("exec_f1", bus.alu_f1, m_f1);
    chk("exec_f2", bus.alu_f2, m_f2);
    bus.alu_c      = c;
    bus.alu_flag   = flg;
    bus.alu_addrch = br;
    bus.alu_naddr  = na;
    step();
    rand_alu();
    chk("post_instr", bus.alu_instr, 0);
    if (op == 7'd127) begin
      chk("halt_flag", halted, 1);
      chk("halt_req", bus.imem_req, 0);
    end else begin
      if (op <= 7) m_reg[rd] = c;
      else if (op <= 13) begin
        m_f2 = m_f1;
        m_f1 = flg;
      end
      if (op == 14 && br) m_pc = na;
      else m_pc = m_pc + 32'd4;
      step();
      chk("next_req", bus.imem_req, 1);
      chk("next_addr", bus.imem_addr, m_pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  op;
    logic [31:0] w;
    bit          hold_ok;
    int          n;

    vt[0] = '{enc(7'd5,  4'd1, 4'd0, 1'b0, 16'h0005), 0, 32'd5,  1'b0, 1'b0, 32'h0,   32'h4,   1'b0, 1'b0};
    vt[1] = '{enc(7'd5,  4'd2, 4'd0, 1'b0, 16'h0007), 0, 32'd7,  1'b0, 1'b0, 32'h0,   32'h8,   1'b0, 1'b0};
    vt[2] = '{enc(7'd0,  4'd3, 4'd1, 1'b0, 16'h0002), 0, 32'd12, 1'b0, 1'b1, 32'h40,  32'hC,   1'b0, 1'b0};
    vt[3] = '{enc(7'd4,  4'd8, 4'd3, 1'b1, 16'h0000), 5, 32'd12, 1'b1, 1'b0, 32'h0,   32'h10,  1'b0, 1'b0};
    vt[4] = '{enc(7'd8,  4'd5, 4'd0, 1'b0, 16'h0000), 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 32'h14, 1'b1, 1'b0};
    vt[5] = '{enc(7'd9,  4'd5, 4'd0, 1'b0, 16'h0000), 2, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h80, 32'h18, 1'b0, 1'b1};
    vt[6] = '{enc(7'd14, 4'd0, 4'd0, 1'b0, 16'h0000), 0, 32'h1234, 1'b0, 1'b1, 32'h100, 32'h100, 1'b0, 1'b1};
    vt[7] = '{enc(7'd14, 4'd0, 4'd0, 1'b0, 16'h0000), 1, 32'h1234, 1'b1, 1'b0, 32'h200, 32'h104, 1'b0, 1'b1};
    vt[8] = '{enc(7'd20, 4'd5, 4'd5, 1'b1, 16'hABCD), 0, 32'h5555, 1'b1, 1'b1, 32'h300, 32'h108, 1'b0, 1'b1};
    vt[9] = '{enc(7'd0,  4'd0, 4'd3, 1'b0, 16'h0008), 0, 32'd24, 1'b0, 1'b0, 32'h0,   32'h10C, 1'b0, 1'b1};

    bus.imem_ack = 1'b0; bus.imem_data = '0;
    bus2.imem_ack = 1'b0; bus2.imem_data = '0;
    bus2.alu_c = '0; bus2.alu_flag = 1'b0; bus2.alu_addrch = 1'b0; bus2.alu_naddr = '0;
    rand_alu();
    model_reset(32'h0);

    step(); step(); step();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", bus.alu_instr, 0);
    chk("rst_a", bus.alu_a, 0);
    chk("rst_value", bus.alu_value, 0);
    chk("rst_flags", {bus.alu_f1, bus.alu_f2}, 0);
    chk("rst_halted", halted, 0);
    chk("rst_wrap_pc", pc2, 32'hFFFF_FFFC);
    reset = 1'b0;

    // PC wrap on the second instance
    n = 0;
    while (bus2.imem_req !== 1'b1 && n < 8) begin step(); n++; end
    chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    bus2.imem_ack  = 1'b1;
    bus2.imem_data = enc(7'd20, 4'd0, 4'd0, 1'b0, 16'h0);
    step();
    bus2.imem_ack  = 1'b0;
    step(); step(); step();
    chk("wrap_req", bus2.imem_req, 1);
    chk("wrap_addr", bus2.imem_addr, 32'h0);

    for (int i = 0; i < 10; i++) begin
      run_instr(vt[i].word, vt[i].wt, vt[i].c, vt[i].flg, vt[i].br, vt[i].na);
      chk($sformatf("vec%0d_pc", i), pc, vt[i].exp_pc);
      chk($sformatf("vec%0d_f1", i), bus.alu_f1, vt[i].exp_f1);
      chk($sformatf("vec%0d_f2", i), bus.alu_f2, vt[i].exp_f2);
    end

    // Reset while a fetch is outstanding, with an ack pending across it
    step(); step();
    reset = 1'b1;
    bus.imem_ack  = 1'b1;
    bus.imem_data = enc(7'd0, 4'd1, 4'd3, 1'b0, 16'h0008);
    step();
    reset = 1'b0;
    chk("mrst_req", bus.imem_req, 0);
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_a", bus.alu_a, 0);
    chk("mrst_f2", bus.alu_f2, 0);
    step();
    bus.imem_ack = 1'b0;
    chk("mrst_refetch", bus.imem_req, 1);
    chk("mrst_addr", bus.imem_addr, 32'h0);
    model_reset(32'h0);
    run_instr(enc(7'd0, 4'd4, 4'd3, 1'b0, 16'h0008), 0, 32'h77, 1'b0, 1'b0, 32'h0);

    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 3))
        0: op = 7'($urandom_range(0, 7));
        1: op = 7'($urandom_range(8, 13));
        2: op = 7'd14;
        default: op = 7'($urandom_range(15, 126));
      endcase
      w = enc(op, 4'($urandom), 4'($urandom), 1'($urandom), 16'($urandom));
      run_instr(w, $urandom_range(0, 3), $urandom, 1'($urandom), 1'($urandom), $urandom);
    end

    run_instr(enc(7'd127, 4'd2, 4'd1, 1'b0, 16'h0003), 1, 32'h99, 1'b1, 1'b1, 32'h500);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.imem_ack  = 1'($urandom);
      bus.imem_data = $urandom;
      step();
      if (bus.imem_req !== 1'b0 || bus.alu_instr !== 7'd0 || halted !== 1'b1 || pc !== m_pc)
        hold_ok = 1'b0;
    end
    bus.imem_ack = 1'b0;
    chk("halt_hold", hold_ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control-side partner of the ALU: fetches 32-bit instruction words, decodes them, and drives the ALU operand, opcode, immediate and high/low inputs.
- Captures the ALU result, flag and branch outputs; writes results back to a 16-entry register file; updates F1/F2 and the program counter.
- Sits between instruction memory and the ALU. It is the only source of `instr` and the only consumer of `C`, `F3`, `addrch` and `naddr`.

Parameters:
- RESET_PC, 32'h0000_0000, program counter value after reset.
- HALT_OP, 7'd127, opcode that stops the sequencer.
- NREGS, 16, register file depth; register 8 is forwarded as `reg8`.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  32  fetch address (current PC).
- imem_ack  input  1  fetch complete; `imem_data` valid this cycle.
- imem_data  input  32  instruction word.
- alu_a  output  32  operand A = R[ra].
- alu_b  output  32  operand B = R[rb].
- alu_reg8  output  32  R[8].
- alu_value  output  16  immediate `imem_data[31:16]` (latched).
- alu_highlow  output  1  instruction bit 15.
- alu_instr  output  7  opcode; 7'd0 when not in EXECUTE.
- alu_f1  output  1  flag F1.
- alu_f2  output  1  flag F2.
- alu_c  input  32  ALU result.
- alu_flag  input  1  ALU compare flag (F3).
- alu_addrch  input  1  branch taken.
- alu_naddr  input  32  branch target.
- halted  output  1  high once HALT_OP has executed.
- pc  output  32  current program counter.

Behaviour:
- Instruction word fields:
  - opcode [6:0]
  - rd [10:7]
  - ra [14:11]
  - highlow [15]
  - rb [19:16]
  - imm [31:16] (overlaps rb by design)
- FSM states: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- Reset:
  - Enters FETCH.
  - pc = RESET_PC; all registers = 0; F1 = F2 = 0; halted = 0.
  - imem_req = 0 in the reset cycle, then 1 from the first cycle after reset.
  - All ALU outputs = 0.
- FETCH:
  - imem_req = 1 and imem_addr = pc, both held stable until imem_ack.
  - On ack, latch imem_data into the instruction register, drop req the next cycle, go to DECODE.
  - Ack in the same cycle as req is legal.
- DECODE: register file read of ra, rb and R8; operands registered into alu_a, alu_b and alu_reg8. Go to EXECUTE.
- EXECUTE:
  - alu_instr = opcode for exactly one cycle.
  - ALU outputs are combinational and sampled at the end of this cycle.
  - Go to WRITEBACK, or to HALT if opcode == HALT_OP.
- WRITEBACK, by opcode:
  - 0–7: R[rd] <= alu_c.
  - 8–13: F2 <= old F1; F1 <= alu_flag; no register write.
  - 14: if alu_addrch then pc <= alu_naddr, else pc <= pc+4.
  - 15–126: no-op (pc+4).
  - For every opcode other than a taken 14, pc <= pc+4.
  - Then go to FETCH.
- Writes to R[rd] are visible to the next instruction's DECODE; no bypass is needed, because WRITEBACK precedes the next DECODE.
- pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- HALT:
  - halted = 1; imem_req = 0; alu_instr = 0.
  - Stays in HALT until reset.
- Reset mid-fetch: req drops the next cycle and any pending ack is ignored; the fetch restarts from RESET_PC.
- imem_ack outside FETCH is ignored.
- Latency: 4 cycles per instruction plus memory wait cycles.

Decomposition:
- Shared package `alu_pkg`:
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_SHL=2, OP_SHR=3, OP_MOV=4, OP_LDL=5, OP_LDH=6, OP_MOV2=7, OP_EQ=8 … OP_NF2=13, OP_BR=14.
  - FSM state encoding.
  - Field bit positions.
- Sub-module `regfile16x32`:
  - 2 asynchronous read ports plus a dedicated R8 tap.
  - 1 synchronous write port.
  - Synchronous reset to zero.

Test Plan:
- Reset then fetch: imem_ack on the first request with the word for ADD rd=3, ra=1, rb=2, R1=5, R2=7, alu_c=12 → alu_instr=0 in EXECUTE; R3=12; pc=4; next imem_addr=4.
- Delayed ack: hold imem_ack low for 5 cycles → imem_req and imem_addr=pc held constant; instruction completes 5 cycles later than the zero-wait case.
- Compare flags: opcode 8 with alu_flag=1, then opcode 9 with alu_flag=0 → after the first, F1=1 and F2=0; after the second, F1=0 and F2=1; no register changes.
- Branch: opcode 14 with alu_addrch=1 and alu_naddr=32'h100 → next imem_addr=32'h100. Same opcode with alu_addrch=0 → imem_addr=pc+4.
- PC wrap: RESET_PC=32'hFFFF_FFFC, NOP instruction → next imem_addr=0.
- Halt and mid-operation reset: opcode 127 → halted=1, imem_req stays 0 for 20 cycles. Separately, assert reset while in FETCH awaiting ack → pc=RESET_PC, registers 0, fetch restarts.
